fft256_reorder: RTL and testbench

FFT256_REORDER -- requirements
Module: fft256_reorder

---
 rtl/fft256_reorder.sv | 166 ++++++++++++++++
 tb/tb_fft256_reorder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft256_reorder.sv
// rtl/fft256_reorder.sv - ping-pong reorder buffer turning 256-point FFT bit-reversed output into natural order
//
// Optional feature macro: FFT_REORDER_ERR_EN (adds the frame_err output and its logic).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   valid_in, sop_in    input bin strobe and first-bin-of-frame marker
//   x_re, x_im          signed input bin, bit-reversed order
//   valid_out, sop_out  output bin strobe and bin-0 marker
//   y_re, y_im          signed output bin, natural order 0..255 (zero when not valid)
//   frame_err           one-cycle pulse on abandoned or dropped frame (FFT_REORDER_ERR_EN only)
module fft256_reorder #(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic                 sop_in,
    input  logic signed [DW-1:0] x_re,
    input  logic signed [DW-1:0] x_im,
    output logic                 valid_out,
    output logic                 sop_out,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im
`ifdef FFT_REORDER_ERR_EN
    ,
    output logic                 frame_err
`endif
);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } wstate_t;

    wstate_t        wstate;
    logic [7:0]     wcnt;
    // bsel selects the bank being written; the other bank is the read bank.
    logic           bsel;
    logic           rd_active;
    logic [7:0]     rd_addr;

    logic [2*DW-1:0] mem0 [256];
    logic [2*DW-1:0] mem1 [256];
    logic [2*DW-1:0] ram_q;
    logic            q_valid;
    logic            q_sop;

    logic            we;
    logic [7:0]      waddr;
    logic            complete;
    logic            can_start;
    logic            start_rd;

    function automatic logic [7:0] bitrev8(input logic [7:0] a);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = a[7-i];
        end
        return r;
    endfunction

    always_comb begin
        we    = 1'b0;
        waddr = 8'd0;
        // A sop always (re)starts a frame at address 0, whatever the state.
        if (valid_in && sop_in) begin
            we    = 1'b1;
            waddr = 8'd0;
        end else if (valid_in && (wstate == S_FILL)) begin
            we    = 1'b1;
            waddr = bitrev8(wcnt);
        end
        complete  = (wstate == S_FILL) && valid_in && !sop_in && (wcnt == 8'hFF);
        // A new read may take over on the very cycle the current read issues
        // its last address, which keeps back-to-back frames gapless.
        can_start = !rd_active || (rd_addr == 8'hFF);
        start_rd  = complete && can_start;
    end

    // Sample storage: no reset needed, the valid pipeline gates all outputs.
    always_ff @(posedge clk) begin
        if (we && !bsel) begin
            mem0[waddr] <= {x_re, x_im};
        end
        if (we && bsel) begin
            mem1[waddr] <= {x_re, x_im};
        end
        ram_q <= bsel ? mem0[rd_addr] : mem1[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate    <= S_IDLE;
            wcnt      <= 8'd0;
            bsel      <= 1'b0;
            rd_active <= 1'b0;
            rd_addr   <= 8'd0;
            q_valid   <= 1'b0;
            q_sop     <= 1'b0;
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
        end else begin
            case (wstate)
                S_IDLE: begin
                    if (valid_in && sop_in) begin
                        wcnt   <= 8'd1;
                        wstate <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (valid_in) begin
                        if (sop_in) begin
                            wcnt <= 8'd1;
                        end else if (wcnt == 8'hFF) begin
                            wcnt   <= 8'd0;
                            wstate <= S_IDLE;
                        end else begin
                            wcnt <= wcnt + 8'd1;
                        end
                    end
                end
            endcase

            if (start_rd) begin
                bsel      <= ~bsel;
                rd_active <= 1'b1;
                rd_addr   <= 8'd0;
            end else if (rd_active) begin
                rd_addr <= rd_addr + 8'd1;
                if (rd_addr == 8'hFF) begin
                    rd_active <= 1'b0;
                end
            end

            // Stage 1 tracks the RAM read, stage 2 is the output register.
            q_valid   <= rd_active;
            q_sop     <= rd_active && (rd_addr == 8'd0);
            valid_out <= q_valid;
            sop_out   <= q_sop;
            y_re      <= q_valid ? ram_q[2*DW-1:DW] : '0;
            y_im      <= q_valid ? ram_q[DW-1:0]    : '0;
        end
    end

`ifdef FFT_REORDER_ERR_EN
    logic abandon;
    logic drop;

    always_comb begin
        abandon = (wstate == S_FILL) && valid_in && sop_in;
        drop    = complete && !can_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= abandon || drop;
        end
    end
`endif

endmodule

// File: tb/tb_fft256_reorder.sv
// tb/tb_fft256_reorder.sv - randomized self-checking bench for fft256_reorder with a frame-level reference model
module tb_fft256_reorder;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 valid_in = 1'b0;
    logic                 sop_in = 1'b0;
    logic signed [DW-1:0] x_re = '0;
    logic signed [DW-1:0] x_im = '0;
    logic                 valid_out;
    logic                 sop_out;
    logic signed [DW-1:0] y_re;
    logic signed [DW-1:0] y_im;
`ifdef FFT_REORDER_ERR_EN
    logic                 frame_err;
`endif

    fft256_reorder #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .sop_in    (sop_in),
        .x_re      (x_re),
        .x_im      (x_im),
        .valid_out (valid_out),
        .sop_out   (sop_out),
        .y_re      (y_re),
        .y_im      (y_im)
`ifdef FFT_REORDER_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Expected output per clock index; entries from before a reset carry an old gen.
    typedef struct {
        bit                   v;
        bit                   sop;
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        bit                   err;
        int                   gen;
    } exp_t;
    exp_t expm [int];
    int   gen = 0;

    logic signed [DW-1:0] fre [256];
    logic signed [DW-1:0] fim [256];
    int fcnt = 0;
    bit in_frame = 0;
    int read_free = 0;
    int last_done = 0;
    int frames_out = 0;

    int vcount = 0, scount = 0, rises = 0, ecount = 0;
    int last_rise = 0, last_sop = 0;
    bit prev_v = 0;

    function automatic int bitrev8(int n);
        int r = 0;
        for (int i = 0; i < 8; i++) r = r * 2 + ((n >> i) & 1);
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic touch(int k);
        if (!expm.exists(k) || expm[k].gen != gen)
            expm[k] = '{v: 1'b0, sop: 1'b0, re: '0, im: '0, err: 1'b0, gen: gen};
    endtask

    // Frame-level model: a frame is 256 accepted samples starting at a sop; its
    // output is the sample at position bitrev8(n) for bin n, two clocks after
    // completion, unless the previous frame's 256-cycle read is still running.
    task automatic model_in(bit v, bit s, logic signed [DW-1:0] re, logic signed [DW-1:0] im, int e);
        if (!v) return;
        if (s) begin
            if (in_frame) begin
                touch(e);
                expm[e].err = 1'b1;
            end
            fre[0] = re; fim[0] = im; fcnt = 1; in_frame = 1;
        end else if (in_frame) begin
            fre[fcnt] = re; fim[fcnt] = im; fcnt++;
            if (fcnt == 256) begin
                in_frame = 0;
                last_done = e;
                if (e >= read_free) begin
                    for (int n = 0; n < 256; n++) begin
                        touch(e + 2 + n);
                        expm[e + 2 + n].v   = 1'b1;
                        expm[e + 2 + n].sop = (n == 0);
                        expm[e + 2 + n].re  = fre[bitrev8(n)];
                        expm[e + 2 + n].im  = fim[bitrev8(n)];
                    end
                    read_free = e + 256;
                    frames_out++;
                end else begin
                    touch(e);
                    expm[e].err = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        bit ev, es, ee;
        logic signed [DW-1:0] er, ei;
        ev = 0; es = 0; ee = 0; er = '0; ei = '0;
        if (expm.exists(cyc) && expm[cyc].gen == gen) begin
            ev = expm[cyc].v; es = expm[cyc].sop; ee = expm[cyc].err;
            er = expm[cyc].re; ei = expm[cyc].im;
        end
        chk("valid_out", valid_out, ev);
        chk("sop_out", sop_out, es);
        chk("y_re", y_re, er);
        chk("y_im", y_im, ei);
`ifdef FFT_REORDER_ERR_EN
        chk("frame_err", frame_err, ee);
        if (frame_err === 1'b1) ecount++;
`else
        if (ee) ecount++;
`endif
        if (valid_out === 1'b1) begin
            vcount++;
            if (!prev_v) begin rises++; last_rise = cyc; end
        end
        if (sop_out === 1'b1) begin scount++; last_sop = cyc; end
        prev_v = (valid_out === 1'b1);
    end

    task automatic drive(bit v, bit s, logic signed [DW-1:0] re, logic signed [DW-1:0] im);
        @(negedge clk);
        valid_in = v; sop_in = s; x_re = re; x_im = im;
        model_in(v, s, re, im, cyc + 1);
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b0, DW'($urandom), DW'($urandom));
    endtask

    // len samples; ramp data re=k/im=-k or random; gap_pct chance of an idle cycle before each sample.
    task automatic send(int len, bit ramp, int gap_pct, bit alt);
        for (int k = 0; k < len; k++) begin
            if (alt && k > 0) idle(1);
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
            if (ramp) drive(1'b1, k == 0, DW'(k), DW'(-k));
            else      drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
        end
    endtask

    int v0, s0, r0, e0, f0, c;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid_out", valid_out, 0);
        chk("reset_sop_out", sop_out, 0);
        chk("reset_y_re", y_re, 0);
        chk("reset_y_im", y_im, 0);
        rst_n = 1'b1;

        // valid without sop from reset is dropped
        v0 = vcount;
        repeat (300) drive(1'b1, 1'b0, DW'($urandom), DW'($urandom));
        idle(5);
        chk("no_sop_outputs", vcount - v0, 0);

        // single ramp frame, continuous
        v0 = vcount; s0 = scount;
        send(256, 1'b1, 0, 1'b0);
        c = last_done;
        chk("model_bin1_re", expm[c + 3].re, 128);
        chk("model_bin1_im", expm[c + 3].im, -128);
        chk("model_bin2_re", expm[c + 4].re, 64);
        chk("model_bin255_re", expm[c + 257].re, 255);
        chk("model_bin0_sop", expm[c + 2].sop, 1);
        idle(262);
        chk("ramp_count", vcount - v0, 256);
        chk("ramp_sops", scount - s0, 1);
        chk("ramp_latency", last_rise - c, 2);

        // two random frames back to back, continuous
        v0 = vcount; s0 = scount; r0 = rises;
        send(256, 1'b0, 0, 1'b0);
        c = last_done;
        send(256, 1'b0, 0, 1'b0);
        idle(262);
        chk("b2b_count", vcount - v0, 512);
        chk("b2b_sops", scount - s0, 2);
        chk("b2b_gapless", rises - r0, 1);
        chk("b2b_second_sop", last_sop - c, 258);

        // ramp frame with valid_in low every other cycle
        v0 = vcount;
        send(256, 1'b1, 0, 1'b1);
        c = last_done;
        idle(262);
        chk("alt_count", vcount - v0, 256);
        chk("alt_latency", last_rise - c, 2);

        // sop restart after 100 samples, then a full frame
        v0 = vcount; s0 = scount; e0 = ecount;
        send(100, 1'b0, 0, 1'b0);
        send(256, 1'b0, 0, 1'b0);
        idle(262);
        chk("restart_count", vcount - v0, 256);
        chk("restart_sops", scount - s0, 1);
        chk("restart_err_events", ecount - e0, 1);

        // random gaps, random restarts, random inter-frame idles
        v0 = vcount; f0 = frames_out;
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(2) == 0) send($urandom_range(1, 254), 1'b0, 20, 1'b0);
            send(256, 1'b0, $urandom_range(0, 40), 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(262);
        chk("random_count", vcount - v0, 256 * (frames_out - f0));

        // reset in the middle of an output frame (bin 50)
        send(256, 1'b0, 0, 1'b0);
        c = last_done;
        while (cyc < c + 51) idle(1);
        @(posedge clk);
        #2;
        chk("pre_reset_valid", valid_out, 1);
        rst_n = 1'b0;
        gen++; in_frame = 0; read_free = 0;
        #1;
        chk("mid_reset_valid", valid_out, 0);
        chk("mid_reset_sop", sop_out, 0);
        chk("mid_reset_y_re", y_re, 0);
        chk("mid_reset_y_im", y_im, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0 = vcount;
        idle(300);
        chk("post_reset_silent", vcount - v0, 0);
        v0 = vcount;
        send(256, 1'b1, 10, 1'b0);
        idle(262);
        chk("post_reset_frame", vcount - v0, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
